// File: rtl/debug_loader.sv
// Debug loader: decodes a byte stream into program-load, run and single-step
// commands for a pipeline and writes the received instruction words to memory.
module debug_loader #(
    parameter int unsigned        NB_REG   = 32,
    parameter int unsigned        NB_BYTE  = 8,
    parameter logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C),
    parameter logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52),
    parameter logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_halt,
    output logic               o_dunit_clk_en,
    output logic               o_dunit_w_en,
    output logic [NB_REG-1:0]  o_dunit_mem_addr,
    output logic [NB_REG-1:0]  o_dunit_mem_data,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned BYTES_PER_WORD = NB_REG / NB_BYTE;
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned IDX_W          = NB_BYTE + 1;
    localparam int unsigned PART_W         = NB_REG - NB_BYTE;
    localparam int unsigned ADDR_SHIFT     = $clog2(NB_REG / 8);

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);
    // A count byte of zero stands for the largest count, 2**NB_BYTE words.
    localparam logic [IDX_W-1:0]  FULL_CNT  = IDX_W'(1) << NB_BYTE;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CNT,
        LOAD_DATA,
        RUN,
        STEP
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    word_cnt;
    logic [IDX_W-1:0]    word_idx;
    logic [BCNT_W-1:0]   byte_cnt;
    logic [PART_W-1:0]   partial_word;
    logic [NB_REG-1:0]   next_word;

    // Word as it stands once the current byte is shifted in (MSB first).
    assign next_word = {partial_word, i_rx_data};

    // Command decode, word assembly and pipeline control.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state            <= IDLE;
            word_cnt         <= '0;
            word_idx         <= '0;
            byte_cnt         <= '0;
            partial_word     <= '0;
            o_dunit_clk_en   <= 1'b0;
            o_dunit_w_en     <= 1'b0;
            o_dunit_mem_addr <= '0;
            o_dunit_mem_data <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            o_dunit_w_en <= 1'b0;
            o_done       <= 1'b0;
            case (state)
                IDLE: begin
                    o_busy         <= 1'b0;
                    o_dunit_clk_en <= 1'b0;
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_LOAD) begin
                            state  <= LOAD_CNT;
                            o_busy <= 1'b1;
                        end else if (i_rx_data == CMD_RUN) begin
                            state          <= RUN;
                            o_busy         <= 1'b1;
                            o_dunit_clk_en <= 1'b1;
                        end else if (i_rx_data == CMD_STEP) begin
                            state          <= STEP;
                            o_busy         <= 1'b1;
                            o_dunit_clk_en <= 1'b1;
                        end
                    end
                end

                LOAD_CNT: begin
                    if (i_rx_valid) begin
                        word_cnt     <= (i_rx_data == '0) ? FULL_CNT : IDX_W'(i_rx_data);
                        word_idx     <= '0;
                        byte_cnt     <= '0;
                        partial_word <= '0;
                        state        <= LOAD_DATA;
                    end
                end

                LOAD_DATA: begin
                    if (i_rx_valid) begin
                        partial_word <= next_word[PART_W-1:0];
                        byte_cnt     <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BCNT_W'(1);
                        if (byte_cnt == LAST_BYTE) begin
                            o_dunit_w_en     <= 1'b1;
                            o_dunit_mem_data <= next_word;
                            o_dunit_mem_addr <= NB_REG'(word_idx) << ADDR_SHIFT;
                            word_idx         <= word_idx + IDX_W'(1);
                            // Busy stays high through the final strobe and drops after it.
                            if (word_idx + IDX_W'(1) == word_cnt) begin
                                o_done <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                end

                RUN: begin
                    if (i_halt) begin
                        o_dunit_clk_en <= 1'b0;
                        o_done         <= 1'b1;
                        o_busy         <= 1'b0;
                        state          <= IDLE;
                    end
                end

                STEP: begin
                    o_dunit_clk_en <= 1'b0;
                    o_busy         <= 1'b0;
                    state          <= IDLE;
                end

                default: begin
                    o_dunit_clk_en <= 1'b0;
                    o_busy         <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_loader.sv
// Self-checking bench for debug_loader: directed command sequences with random
// payload bytes, checked against an arithmetic model of the expected writes.
module tb_debug_loader;

    typedef logic [7:0] byte_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        logic        busy;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    byte_t       rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        halt = 1'b0;
    logic        clk_en;
    logic        w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    wr_t wq[$];
    int  clken_cnt = 0;
    int  done_cnt = 0;
    int  overlap_cnt = 0;

    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    debug_loader dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_rx_data        (rx_data),
        .i_rx_valid       (rx_valid),
        .i_halt           (halt),
        .o_dunit_clk_en   (clk_en),
        .o_dunit_w_en     (w_en),
        .o_dunit_mem_addr (mem_addr),
        .o_dunit_mem_data (mem_data),
        .o_busy           (busy),
        .o_done           (done)
    );

    always #5 clk = ~clk;

    // Observe outputs mid-cycle and log every event of interest.
    always @(negedge clk) begin
        if (rst_n) begin
            if (w_en) wq.push_back('{addr: mem_addr, data: mem_data, done: done, busy: busy});
            if (clk_en) clken_cnt++;
            if (done) done_cnt++;
            if (clk_en && w_en) overlap_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input byte_t b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " clk_en"}, 32'(clk_en), 32'd0);
        chk({tag, " w_en"}, 32'(w_en), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " addr"}, mem_addr, 32'd0);
        chk({tag, " data"}, mem_data, 32'd0);
    endtask

    // Load a program and compare every write against words built from the byte list.
    task automatic load_and_check(input string tag, input byte_t cnt, input byte_t data[$],
                                  input int max_gap);
        int          n;
        int          wq0;
        int          done0;
        int          clk0;
        logic [31:0] w;
        n     = (cnt == 8'd0) ? 256 : int'(cnt);
        wq0   = wq.size();
        done0 = done_cnt;
        clk0  = clken_cnt;
        send(8'h4C);
        send(cnt);
        foreach (data[i]) begin
            send(data[i]);
            if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
        end
        idle(3);
        chk({tag, " write count"}, 32'(wq.size() - wq0), 32'(n));
        w = '0;
        for (int k = 0; k < n && wq0 + k < wq.size(); k++) begin
            w = (32'(data[4*k]) << 24) | (32'(data[4*k+1]) << 16) |
                (32'(data[4*k+2]) << 8) | 32'(data[4*k+3]);
            chk($sformatf("%s addr[%0d]", tag, k), wq[wq0+k].addr, 32'(4 * k));
            chk($sformatf("%s data[%0d]", tag, k), wq[wq0+k].data, w);
            chk($sformatf("%s done[%0d]", tag, k), 32'(wq[wq0+k].done), 32'(k == n - 1));
            chk($sformatf("%s busy[%0d]", tag, k), 32'(wq[wq0+k].busy), 32'd1);
        end
        chk({tag, " done pulses"}, 32'(done_cnt - done0), 32'd1);
        chk({tag, " clk_en during load"}, 32'(clken_cnt - clk0), 32'd0);
        chk({tag, " busy after"}, 32'(busy), 32'd0);
        last_addr = 32'(4 * (n - 1));
        last_data = w;
    endtask

    initial begin
        byte_t q[$];
        int    wq0;
        int    done0;
        int    clk0;

        // Reset state
        idle(2);
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk_zero_outputs("post-reset idle");

        // Single-word load with fixed bytes
        q = '{8'h20, 8'h08, 8'h00, 8'h05};
        load_and_check("single", 8'h01, q, 0);
        chk("single word value", last_data, 32'h2008_0005);

        // Unknown byte in IDLE changes nothing; write bus holds last values
        wq0 = wq.size(); clk0 = clken_cnt; done0 = done_cnt;
        send(8'h7F);
        idle(3);
        chk("ignored writes", 32'(wq.size() - wq0), 32'd0);
        chk("ignored clk_en", 32'(clken_cnt - clk0), 32'd0);
        chk("ignored done", 32'(done_cnt - done0), 32'd0);
        chk("ignored busy", 32'(busy), 32'd0);
        chk("held addr", mem_addr, last_addr);
        chk("held data", mem_data, last_data);

        // Back-to-back three-word load with random bytes, command values included
        q = {};
        for (int i = 0; i < 12; i++) q.push_back(byte_t'($urandom));
        q[1] = 8'h52;
        q[6] = 8'h4C;
        load_and_check("b2b", 8'h03, q, 0);

        // Gapped two-word load
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(byte_t'($urandom));
        load_and_check("gapped", 8'h02, q, 3);

        // Run until halt, with a byte arriving mid-run that must be ignored
        wq0 = wq.size(); clk0 = clken_cnt; done0 = done_cnt;
        send(8'h52);
        idle(3);
        send(8'h4C);
        idle(6);
        halt = 1'b1;
        idle(3);
        halt = 1'b0;
        chk("run clk_en cycles", 32'(clken_cnt - clk0), 32'd11);
        chk("run done pulses", 32'(done_cnt - done0), 32'd1);
        chk("run busy after", 32'(busy), 32'd0);
        chk("run clk_en after", 32'(clk_en), 32'd0);
        chk("run writes", 32'(wq.size() - wq0), 32'd0);

        // Run entered with halt already high gives a single enable cycle
        halt = 1'b1;
        clk0 = clken_cnt; done0 = done_cnt;
        send(8'h52);
        idle(4);
        chk("run-halted clk_en cycles", 32'(clken_cnt - clk0), 32'd1);
        chk("run-halted done", 32'(done_cnt - done0), 32'd1);

        // Single step ignores halt and does not pulse done
        clk0 = clken_cnt; done0 = done_cnt;
        send(8'h53);
        idle(3);
        halt = 1'b0;
        chk("step clk_en cycles", 32'(clken_cnt - clk0), 32'd1);
        chk("step done", 32'(done_cnt - done0), 32'd0);
        chk("step busy after", 32'(busy), 32'd0);

        // Reset in the middle of the second word of a two-word load
        wq0 = wq.size();
        send(8'h4C);
        send(8'h02);
        for (int i = 0; i < 6; i++) send(byte_t'($urandom));
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("mid-load reset");
        idle(3);
        chk("mid-load writes", 32'(wq.size() - wq0), 32'd1);
        rst_n = 1'b1;
        idle(1);
        clk0 = clken_cnt;
        send(8'h53);
        idle(3);
        chk("after-reset step", 32'(clken_cnt - clk0), 32'd1);
        chk("after-reset writes", 32'(wq.size() - wq0), 32'd1);
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(byte_t'($urandom));
        load_and_check("after-reset load", 8'h01, q, 0);

        // Count byte of zero loads 256 words
        q = {};
        for (int i = 0; i < 1024; i++) q.push_back(byte_t'($urandom));
        load_and_check("count0", 8'h00, q, 0);
        chk("count0 last addr", last_addr, 32'd1020);

        chk("clk_en/w_en overlap", 32'(overlap_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_loader.md
DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 The block SHALL have parameter NB_REG, default 32, meaning the instruction word and memory address width.
REQ-002 The block SHALL have parameter NB_BYTE, default 8, meaning the received byte width.
REQ-003 The block SHALL have parameter CMD_LOAD, default 8'h4C ('L'), meaning the load-program command byte.
REQ-004 The block SHALL have parameter CMD_RUN, default 8'h52 ('R'), meaning the continuous-run command byte.
REQ-005 The block SHALL have parameter CMD_STEP, default 8'h53 ('S'), meaning the single-step command byte.
REQ-006 The block SHALL have the following ports:
- i_clk  input  1  single clock; all state changes on the rising edge.
- i_reset  input  1  reset, asynchronous and active-low.
- i_rx_data  input  NB_BYTE  received byte, valid only while i_rx_valid=1.
- i_rx_valid  input  1  one-cycle strobe per received byte.
- i_halt  input  1  pipeline reports halt instruction reached.
- o_dunit_clk_en  output  1  pipeline clock enable.
- o_dunit_w_en  output  1  instruction-memory write strobe.
- o_dunit_mem_addr  output  NB_REG  byte address of the word being written.
- o_dunit_mem_data  output  NB_REG  instruction word being written.
- o_busy  output  1  high in any state other than IDLE.
- o_done  output  1  one-cycle pulse at end of a load or a run.

Function
REQ-007 The FSM SHALL have states IDLE, LOAD_CNT, LOAD_DATA, RUN and STEP, and all outputs SHALL be registered.
REQ-008 In IDLE, bytes SHALL be decoded as follows:
- CMD_LOAD -> LOAD_CNT.
- CMD_RUN -> RUN.
- CMD_STEP -> STEP.
- Any other byte is ignored, and the state stays IDLE.
REQ-009 In LOAD_CNT, the next byte SHALL be latched as word count N, where 0 means 256; the word index and byte counter are cleared; the state moves to LOAD_DATA.
REQ-010 In LOAD_DATA, bytes SHALL be assembled MSB-first, so the first byte lands in [31:24] and the fourth byte in [7:0].
REQ-011 On the 4th byte of a word, the next cycle SHALL drive all of the following for exactly one cycle:
- o_dunit_w_en=1.
- o_dunit_mem_data = the assembled word.
- o_dunit_mem_addr = word_index*4, with the first word at address 0.
REQ-012 The word index SHALL increment after each write, and the byte counter SHALL wrap 3->0 so that back-to-back bytes arriving during the write cycle are accepted with no loss and no extra state.
REQ-013 After the Nth write, the FSM SHALL return to IDLE and o_done SHALL pulse in the same cycle as the final o_dunit_w_en.
REQ-014 During LOAD_CNT and LOAD_DATA, o_dunit_clk_en SHALL be 0, and command byte values SHALL be treated as data.
REQ-015 In RUN, o_dunit_clk_en SHALL be 1 starting the cycle after the CMD_RUN byte.
REQ-016 In RUN, when i_halt=1 is sampled, the next cycle SHALL have o_dunit_clk_en=0, o_done=1 for one cycle, and state IDLE; if i_halt is already 1 on entry, exactly one enable cycle SHALL occur.
REQ-017 In RUN, received bytes SHALL be ignored.
REQ-018 In STEP, o_dunit_clk_en SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE; o_done SHALL NOT pulse, and i_halt SHALL be ignored.
REQ-019 o_dunit_clk_en and o_dunit_w_en SHALL never be 1 in the same cycle.
REQ-020 o_dunit_mem_addr and o_dunit_mem_data SHALL hold their last values when o_dunit_w_en=0.
REQ-021 The word index SHALL be 9 bits so that N=256 produces addresses 0..1020 with no wrap-around.
REQ-022 o_busy SHALL be 0 in IDLE and 1 in every other state, including the cycle of a write strobe.

Reset
REQ-023 While i_reset=0, all of the following SHALL hold:
- State is IDLE.
- o_dunit_clk_en, o_dunit_w_en, o_busy and o_done are 0.
- o_dunit_mem_addr and o_dunit_mem_data are 0.
- The word index, byte counter and word count are 0.
REQ-024 Reset asserted mid-load or mid-run SHALL abort immediately with no further write strobe or enable cycle, and a partially assembled word SHALL be discarded.
REQ-025 After reset release, the first accepted byte SHALL be decoded as a command.

Verification
REQ-026 The bench SHALL cover single-word load: bytes 4C,01,20,08,00,05 -> one w_en with addr 0, data 32'h20080005, o_done in the same cycle, then IDLE.
REQ-027 The bench SHALL cover back-to-back load with no idle cycles: 4C,03 then 12 bytes -> writes at 0, 4 and 8 with correct words, and no byte dropped.
REQ-028 The bench SHALL cover run until halt: 52, then i_halt raised 10 cycles later -> clk_en high for 11 cycles, then 0, o_done pulses once, o_busy falls.
REQ-029 The bench SHALL cover single step and ignored bytes: 53 -> exactly one clk_en cycle; byte 7F in IDLE -> no output change.
REQ-030 The bench SHALL cover reset mid-load: 4C,02 and 6 bytes, then i_reset=0 -> only one write occurs, outputs return to 0, and a following 53 produces one step.
REQ-031 The bench SHALL cover count 0: 4C,00 and 1024 bytes -> 256 writes with last addr 1020, and no clk_en during the load.
